calc_key_sequencer: RTL and testbench

Control FSM between the 4x4 keypad inputs and the calculator arithmetic unit. Synchronises and edge-detects key strobes, assembles two 4-digit BCD operands and an operator, and hands the operation to the arithmetic unit over a valid/ready handshake. It then waits for the result with a timeout and drives the 16-bit display register that feeds the output pins.

---
 rtl/calc_key_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_calc_key_sequencer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_key_sequencer.sv
// -----------------------------------------------------------------------------
// calc_key_sequencer
//
// Control FSM between the 4x4 keypad and the calculator arithmetic unit.
// The raw key strobe is synchronised and edge-detected into one event per
// press. Digits are assembled into two 4-digit BCD operands, an operator is
// latched, and the operation is handed to the arithmetic unit over a
// valid/ready handshake. The FSM then waits for the result, with a timeout,
// and drives the display register.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   key_pressed  raw keypad strobe (level while held)
//   keypad_out   key code, stable while key_pressed is high
//   op_a, op_b   BCD operands presented to the arithmetic unit
//   op_code      00 add, 01 sub, 10 mul, 11 div
//   op_valid     operation request, held until op_ready
//   op_ready     arithmetic unit accept
//   res_valid    one-cycle result strobe
//   res_data     BCD result
//   res_err      unit error, qualified by res_valid
//   disp         display value (4 BCD digits)
//   disp_err     high while an error is shown
//   busy         high while an operation is outstanding (EXEC/WAIT)
// -----------------------------------------------------------------------------
module calc_key_sequencer #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        key_pressed,
   input  logic [3:0]  keypad_out,
   output logic [15:0] op_a,
   output logic [15:0] op_b,
   output logic [1:0]  op_code,
   output logic        op_valid,
   input  logic        op_ready,
   input  logic        res_valid,
   input  logic [15:0] res_data,
   input  logic        res_err,
   output logic [15:0] disp,
   output logic        disp_err,
   output logic        busy
);

   localparam logic [7:0] TMO_LIM = 8'(TIMEOUT);

   typedef enum logic [2:0] {
      ST_ENTA,
      ST_ENTB,
      ST_EXEC,
      ST_WAIT,
      ST_SHOW
   } state_t;

   state_t      state_q, state_d;
   logic        sync1_q, sync2_q, sync3_q;
   logic [3:0]  key_q;
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   logic [1:0]  op_q, op_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [7:0]  tmo_q, tmo_d;
   logic [15:0] disp_q, disp_d;
   logic        disp_err_q, disp_err_d;

   // Key event decode
   logic       key_evt;
   logic       is_digit, is_oper, is_eq, is_clr;
   logic [1:0] key_op;
   logic       digits_full;

   assign key_evt     = sync2_q & ~sync3_q;
   assign is_digit    = key_evt && (key_q <= 4'h9);
   assign is_oper     = key_evt && (key_q >= 4'hA) && (key_q <= 4'hD);
   assign is_eq       = key_evt && (key_q == 4'hE);
   assign is_clr      = key_evt && (key_q == 4'hF);
   // 0xA..0xD map onto 00..11: the low two bits minus 2, modulo 4
   assign key_op      = key_q[1:0] - 2'd2;
   assign digits_full = (cnt_q == 3'd4);

   // Synchroniser chain plus key-code capture. The code is taken on the same
   // edge the first flop sees the strobe rise, while keypad_out is known to be
   // stable, so the code register is valid by the time the event fires.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sync3_q <= 1'b0;
         key_q   <= 4'h0;
      end else begin
         sync1_q <= key_pressed;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
         if (key_pressed && !sync1_q) begin
            key_q <= keypad_out;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_ENTA;
         a_q        <= 16'h0;
         b_q        <= 16'h0;
         op_q       <= 2'b00;
         cnt_q      <= 3'd0;
         tmo_q      <= 8'd0;
         disp_q     <= 16'h0;
         disp_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         a_q        <= a_d;
         b_q        <= b_d;
         op_q       <= op_d;
         cnt_q      <= cnt_d;
         tmo_q      <= tmo_d;
         disp_q     <= disp_d;
         disp_err_q <= disp_err_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      a_d        = a_q;
      b_d        = b_q;
      op_d       = op_q;
      cnt_d      = cnt_q;
      tmo_d      = tmo_q;
      disp_d     = disp_q;
      disp_err_d = disp_err_q;

      if (is_clr) begin
         // Clear overrides everything, including a pending request or an
         // outstanding result, which is then simply never listened to.
         state_d    = ST_ENTA;
         a_d        = 16'h0;
         b_d        = 16'h0;
         op_d       = 2'b00;
         cnt_d      = 3'd0;
         disp_d     = 16'h0;
         disp_err_d = 1'b0;
      end else begin
         case (state_q)
            ST_ENTA: begin
               if (is_digit && !digits_full) begin
                  a_d    = {a_q[11:0], key_q};
                  cnt_d  = cnt_q + 3'd1;
                  disp_d = {a_q[11:0], key_q};
               end else if (is_oper) begin
                  op_d    = key_op;
                  b_d     = 16'h0;
                  cnt_d   = 3'd0;
                  disp_d  = a_q;
                  state_d = ST_ENTB;
               end
            end
            ST_ENTB: begin
               if (is_digit && !digits_full) begin
                  b_d    = {b_q[11:0], key_q};
                  cnt_d  = cnt_q + 3'd1;
                  disp_d = {b_q[11:0], key_q};
               end else if (is_oper && (cnt_q == 3'd0)) begin
                  op_d = key_op;
               end else if (is_eq) begin
                  // B was cleared on entry to ENTB, so no digits means B=0
                  state_d = ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (op_ready) begin
                  tmo_d   = 8'd0;
                  state_d = ST_WAIT;
               end
            end
            ST_WAIT: begin
               // A result arriving on the expiry cycle takes precedence
               if (res_valid) begin
                  disp_d     = res_err ? 16'hEEEE : res_data;
                  disp_err_d = res_err;
                  state_d    = ST_SHOW;
               end else if (tmo_q == TMO_LIM) begin
                  disp_d     = 16'hEEEE;
                  disp_err_d = 1'b1;
                  state_d    = ST_SHOW;
               end else begin
                  tmo_d = tmo_q + 8'd1;
               end
            end
            ST_SHOW: begin
               if (is_digit) begin
                  a_d        = {12'h000, key_q};
                  cnt_d      = 3'd1;
                  disp_d     = {12'h000, key_q};
                  disp_err_d = 1'b0;
                  state_d    = ST_ENTA;
               end else if (is_oper && !disp_err_q) begin
                  // Without an error the display register holds the result
                  a_d     = disp_q;
                  b_d     = 16'h0;
                  cnt_d   = 3'd0;
                  op_d    = key_op;
                  state_d = ST_ENTB;
               end
            end
            default: begin
               state_d = ST_ENTA;
            end
         endcase
      end
   end

   assign op_a     = a_q;
   assign op_b     = b_q;
   assign op_code  = op_q;
   assign op_valid = (state_q == ST_EXEC);
   assign busy     = (state_q == ST_EXEC) || (state_q == ST_WAIT);
   assign disp     = disp_q;
   assign disp_err = disp_err_q;

endmodule

// File: tb/tb_calc_key_sequencer.sv
// -----------------------------------------------------------------------------
// tb_calc_key_sequencer
//
// Directed bench for calc_key_sequencer: key entry, handshake, result,
// backpressure, chaining, error/timeout, clear in EXEC and async reset.
// Inputs are driven on the falling edge; outputs are sampled on the falling
// edge, away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_calc_key_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        key_pressed;
   logic [3:0]  keypad_out;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic [1:0]  op_code;
   logic        op_valid;
   logic        op_ready;
   logic        res_valid;
   logic [15:0] res_data;
   logic        res_err;
   logic [15:0] disp;
   logic        disp_err;
   logic        busy;

   int n_cmp = 0;
   int n_bad = 0;
   int xfers = 0;

   calc_key_sequencer #(.TIMEOUT(255)) dut (
      .clk         (clk),
      .rst         (rst),
      .key_pressed (key_pressed),
      .keypad_out  (keypad_out),
      .op_a        (op_a),
      .op_b        (op_b),
      .op_code     (op_code),
      .op_valid    (op_valid),
      .op_ready    (op_ready),
      .res_valid   (res_valid),
      .res_data    (res_data),
      .res_err     (res_err),
      .disp        (disp),
      .disp_err    (disp_err),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Handshake transfers, seen with pre-edge values at the rising edge
   always @(posedge clk) begin
      if (!rst && op_valid && op_ready) xfers++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One press: hold 3 cycles (event processed by then), release 3 cycles
   task automatic press(input logic [3:0] code);
      keypad_out  = code;
      key_pressed = 1'b1;
      tick(3);
      key_pressed = 1'b0;
      tick(3);
   endtask

   task automatic result(input logic [15:0] data, input logic err);
      res_valid = 1'b1;
      res_data  = data;
      res_err   = err;
      tick(1);
      res_valid = 1'b0;
      res_err   = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst         = 1'b1;
      key_pressed = 1'b0;
      keypad_out  = 4'h0;
      op_ready    = 1'b0;
      res_valid   = 1'b0;
      res_data    = 16'h0;
      res_err     = 1'b0;
      tick(2);
      chk("rst_disp", 32'(disp), 32'h0);
      chk("rst_opvalid", 32'(op_valid), 32'h0);
      rst = 1'b0;
      tick(1);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_opa", 32'(op_a), 32'h0);
      chk("rst_err", 32'(disp_err), 32'h0);

      // Key latency: visible after edge k+2
      keypad_out  = 4'h1;
      key_pressed = 1'b1;
      tick(1);
      chk("lat_k", 32'(disp), 32'h0);
      tick(1);
      chk("lat_k1", 32'(disp), 32'h0);
      tick(1);
      chk("lat_k2", 32'(disp), 32'h0001);
      key_pressed = 1'b0;
      tick(3);

      // Entry, 5th digit ignored
      press(4'h2); press(4'h3); press(4'h4);
      chk("entry_4dig", 32'(disp), 32'h1234);
      press(4'h5);
      chk("entry_5th", 32'(disp), 32'h1234);
      chk("entry_opa", 32'(op_a), 32'h1234);

      // Clear, then a long hold gives one event
      press(4'hF);
      chk("clr_disp", 32'(disp), 32'h0);
      chk("clr_opa", 32'(op_a), 32'h0);
      keypad_out  = 4'h7;
      key_pressed = 1'b1;
      tick(20);
      key_pressed = 1'b0;
      tick(3);
      chk("hold_one", 32'(disp), 32'h0007);
      press(4'h8);
      chk("hold_next", 32'(disp), 32'h0078);

      // Add 12 + 34 with op_ready high
      press(4'hF);
      op_ready = 1'b1;
      press(4'h1); press(4'h2);
      chk("add_a", 32'(disp), 32'h0012);
      press(4'hA);
      chk("add_entb_shows_a", 32'(disp), 32'h0012);
      press(4'h3); press(4'h4);
      chk("add_b", 32'(disp), 32'h0034);
      press(4'hE);
      chk("add_opa", 32'(op_a), 32'h0012);
      chk("add_opb", 32'(op_b), 32'h0034);
      chk("add_code", 32'(op_code), 32'h0);
      chk("add_xfers", 32'(xfers), 32'd1);
      chk("add_wait_busy", 32'(busy), 32'h1);
      chk("add_wait_valid", 32'(op_valid), 32'h0);
      op_ready = 1'b0;
      result(16'h0046, 1'b0);
      chk("add_res_disp", 32'(disp), 32'h0046);
      chk("add_res_busy", 32'(busy), 32'h0);
      chk("add_res_err", 32'(disp_err), 32'h0);

      // Backpressure: 3 + 6 held 10 cycles
      press(4'hF);
      press(4'h3); press(4'hA); press(4'h6); press(4'hE);
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("bp_valid_%0d", i), 32'(op_valid), 32'h1);
         chk($sformatf("bp_ops_%0d", i), {op_a, op_b}, 32'h0003_0006);
         tick(1);
      end
      chk("bp_noxfer", 32'(xfers), 32'd1);
      op_ready = 1'b1;
      tick(1);
      op_ready = 1'b0;
      chk("bp_drop", 32'(op_valid), 32'h0);
      chk("bp_busy", 32'(busy), 32'h1);
      chk("bp_xfers", 32'(xfers), 32'd2);
      result(16'h0009, 1'b0);
      chk("bp_res", 32'(disp), 32'h0009);

      // Chain from the result: B, 2, E
      press(4'hB);
      chk("ch_opa", 32'(op_a), 32'h0009);
      chk("ch_disp_a", 32'(disp), 32'h0009);
      press(4'h2);
      chk("ch_disp_b", 32'(disp), 32'h0002);
      press(4'hE);
      chk("ch_valid", 32'(op_valid), 32'h1);
      chk("ch_code", 32'(op_code), 32'h1);
      chk("ch_opb", 32'(op_b), 32'h0002);
      op_ready = 1'b1;
      tick(1);
      op_ready = 1'b0;
      chk("ch_xfers", 32'(xfers), 32'd3);

      // Error result; operator ignored afterwards
      result(16'h1234, 1'b1);
      chk("err_disp", 32'(disp), 32'hEEEE);
      chk("err_flag", 32'(disp_err), 32'h1);
      press(4'hA);
      chk("err_op_disp", 32'(disp), 32'hEEEE);
      chk("err_op_flag", 32'(disp_err), 32'h1);
      chk("err_op_valid", 32'(op_valid), 32'h0);
      press(4'h5);
      chk("err_digit_disp", 32'(disp), 32'h0005);
      chk("err_digit_flag", 32'(disp_err), 32'h0);
      chk("err_digit_opa", 32'(op_a), 32'h0005);

      // Timeout: SHOW exactly TIMEOUT+1 cycles after the transfer edge
      press(4'hA); press(4'hE);
      chk("tmo_opb_zero", 32'(op_b), 32'h0);
      op_ready = 1'b1;
      tick(1);
      op_ready = 1'b0;
      chk("tmo_xfers", 32'(xfers), 32'd4);
      tick(255);
      chk("tmo_still_busy", 32'(busy), 32'h1);
      tick(1);
      chk("tmo_busy", 32'(busy), 32'h0);
      chk("tmo_disp", 32'(disp), 32'hEEEE);
      chk("tmo_flag", 32'(disp_err), 32'h1);

      // Result on the expiry cycle wins
      press(4'h1); press(4'hA); press(4'hE);
      op_ready = 1'b1;
      tick(1);
      op_ready = 1'b0;
      tick(255);
      chk("race_busy", 32'(busy), 32'h1);
      result(16'h0077, 1'b0);
      chk("race_disp", 32'(disp), 32'h0077);
      chk("race_flag", 32'(disp_err), 32'h0);
      chk("race_xfers", 32'(xfers), 32'd5);

      // Clear during EXEC without acceptance
      press(4'hF);
      press(4'h1); press(4'hA); press(4'h2); press(4'hE);
      chk("cx_valid", 32'(op_valid), 32'h1);
      press(4'hF);
      chk("cx_drop", 32'(op_valid), 32'h0);
      chk("cx_busy", 32'(busy), 32'h0);
      chk("cx_disp", 32'(disp), 32'h0);
      chk("cx_ops", {op_a, op_b}, 32'h0);
      result(16'h1111, 1'b0);
      chk("cx_late_disp", 32'(disp), 32'h0);
      chk("cx_late_busy", 32'(busy), 32'h0);
      op_ready = 1'b1;
      tick(3);
      op_ready = 1'b0;
      chk("cx_xfers", 32'(xfers), 32'd5);

      // Async reset mid-WAIT
      op_ready = 1'b1;
      press(4'h4); press(4'hA); press(4'h5); press(4'hE);
      op_ready = 1'b0;
      chk("ar_wait", 32'(busy), 32'h1);
      chk("ar_opa_pre", 32'(op_a), 32'h0004);
      rst = 1'b1;
      #1;
      chk("ar_opa", 32'(op_a), 32'h0);
      chk("ar_opb", 32'(op_b), 32'h0);
      chk("ar_busy", 32'(busy), 32'h0);
      chk("ar_disp", 32'(disp), 32'h0);
      chk("ar_misc", {op_code, op_valid, disp_err}, 32'h0);
      tick(1);
      rst = 1'b0;
      tick(1);
      chk("ar_after_busy", 32'(busy), 32'h0);
      press(4'h3);
      chk("ar_enta", 32'(disp), 32'h0003);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
